// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external adder between NUM_REQ requesters.
// Winning operands are registered, given a full settle cycle, then the sum is returned with the requester id.
module adder_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [A_WIDTH-1:0]           add_a,
  output logic [B_WIDTH-1:0]           add_b,
  input  logic [OUT_WIDTH-1:0]         add_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [OUT_WIDTH-1:0]         rsp_data,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ID_WIDTH-1:0]  rr_ptr_r;
  logic [ID_WIDTH-1:0]  id_r;
  logic [A_WIDTH-1:0]   add_a_r;
  logic [B_WIDTH-1:0]   add_b_r;
  logic                 rsp_valid_r;
  logic [ID_WIDTH-1:0]  rsp_id_r;
  logic [OUT_WIDTH-1:0] rsp_data_r;

  logic                 grant_found_s;
  logic [ID_WIDTH-1:0]  grant_id_s;
  logic [A_WIDTH-1:0]   grant_a_s;
  logic [B_WIDTH-1:0]   grant_b_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // Round-robin scan of req_valid starting at rr_ptr, first set bit wins.
  always_comb begin : arb_comb
    int idx_v;
    idx_v         = 0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    grant_a_s     = '0;
    grant_b_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v = int'(rr_ptr_r) + k;
      idx_v = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
      if (!grant_found_s && req_valid[idx_v]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_WIDTH'(idx_v);
        grant_a_s     = req_a[idx_v*A_WIDTH +: A_WIDTH];
        grant_b_s     = req_b[idx_v*B_WIDTH +: B_WIDTH];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and grant decode; req_ready only ever asserted while IDLE.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = '0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          req_ready_s[grant_id_s] = 1'b1;
          state_nxt_s             = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: state_nxt_s = RESP;
      RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operands only change on accept; add_out only sampled at the end of SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      id_r        <= '0;
      add_a_r     <= '0;
      add_b_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            add_a_r  <= grant_a_s;
            add_b_r  <= grant_b_s;
            id_r     <= grant_id_s;
            rr_ptr_r <= (grant_id_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_WIDTH'(1);
          end
        end
        SETTLE: begin
          rsp_data_r  <= add_out;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_adder_share_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int OW = 17;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [AW-1:0]   add_a;
  logic [BW-1:0]   add_b;
  logic [OW-1:0]   add_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [OW-1:0]   rsp_data;
  logic            busy;

  always #5 clk = ~clk;

  // Shared adder stand-in: signed sum with sign extension.
  assign add_out = {add_a[AW-1], add_a} + {add_b[BW-1], add_b};

  adder_share_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = free, 1 = waiting for the adder, 2 = response pending.
  int          m_phase;
  int          m_ptr;
  int          m_id;
  int          m_rid;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic [OW-1:0] m_rdata;
  int          last_grant;
  bit          auto_drop;
  int          log_id[$];
  logic [OW-1:0] log_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_id = 0; m_rid = 0;
    m_a = '0; m_b = '0; m_rdata = '0;
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_ready;
    int g;
    int s;
    g = -1;
    exp_ready = '0;
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("onehot0", 32'($onehot0(req_ready)), 32'd1);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("add_a", 32'(add_a), 32'(m_a));
    chk("add_b", 32'(add_b), 32'(m_b));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
    if (rsp_valid && rsp_ready) begin
      log_id.push_back(int'(rsp_id));
      log_data.push_back(rsp_data);
    end
    last_grant = g;
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
             m_a = req_a[g*AW +: AW];
             m_b = req_b[g*BW +: BW];
             m_id = g;
             m_ptr = (g + 1) % N;
             m_phase = 1;
           end
        1: begin
             s = int'($signed(m_a)) + int'($signed(m_b));
             m_rdata = OW'(s);
             m_rid = m_id;
             m_phase = 2;
           end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (auto_drop && last_grant >= 0) req_valid[last_grant] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  initial begin
    int exp_ids[5];
    logic [OW-1:0] exp_data[5];
    exp_ids  = '{0, 1, 2, 3, 0};
    exp_data = '{17'd0, 17'd11, 17'd22, 17'd33, 17'd0};
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    auto_drop = 1'b1; last_grant = -1;
    model_reset();
    do_reset();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);

    // Single request from requester 2: 100 + (-30).
    set_req(2, 16'd100, -16'sd30);
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    step();
    chk("single_busy_settle", 32'(busy), 32'd1);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'd0);
    step();
    chk("single_busy_resp", 32'(busy), 32'd1);
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    chk("single_rsp_data", 32'(rsp_data), 32'd70);
    step();
    chk("single_idle", 32'(busy), 32'd0);

    // Wrap-around: pointer sits at 3, requesters 1 and 3 compete.
    set_req(1, 16'd5, 16'd6);
    set_req(3, 16'd7, 16'd8);
    req_valid = 4'b1010;
    log_id.delete(); log_data.delete();
    #1 chk("wrap_first_ready", 32'(req_ready), 32'h8);
    repeat (6) step();
    chk("wrap_count", 32'(log_id.size()), 32'd2);
    if (log_id.size() == 2) begin
      chk("wrap_id0", 32'(log_id[0]), 32'd3);
      chk("wrap_id1", 32'(log_id[1]), 32'd1);
      chk("wrap_data0", 32'(log_data[0]), 32'd15);
      chk("wrap_data1", 32'(log_data[1]), 32'd11);
    end
    req_valid = 4'b1111;
    #1 chk("wrap_ptr_at_2", 32'(req_ready), 32'h4);
    req_valid = '0;

    // Full contention after reset.
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i), BW'(10 * i));
    req_valid = 4'b1111;
    log_id.delete(); log_data.delete();
    repeat (15) step();
    req_valid = '0;
    auto_drop = 1'b1;
    chk("cont_count", 32'(log_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_id.size(); i++) begin
      chk("cont_id", 32'(log_id[i]), 32'(exp_ids[i]));
      chk("cont_data", 32'(log_data[i]), 32'(exp_data[i]));
    end

    // Backpressure: -32768 + -1 held while rsp_ready is low.
    set_req(0, 16'h8000, 16'hFFFF);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    step();
    set_req(1, 16'd3, 16'd4);
    req_valid[1] = 1'b1;
    step();
    repeat (5) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h17FFF);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_grant", 32'(req_ready), 32'h2);
    repeat (4) step();

    // Reset during SETTLE drops the transaction.
    set_req(1, 16'd9, 16'd9);
    req_valid = 4'b0010;
    step();
    chk("midrst_in_settle", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_add_a", 32'(add_a), 32'd0);
    chk("midrst_add_b", 32'(add_b), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    repeat (4) step();
    req_valid = 4'b1111;
    #1 chk("midrst_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Idle stability.
    set_req(2, 16'd1234, 16'd4321);
    req_valid = 4'b0100;
    repeat (4) step();
    repeat (20) begin
      step();
      chk("idle_add_a", 32'(add_a), 32'd1234);
      chk("idle_add_b", 32'(add_b), 32'd4321);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
    end

    // Randomized traffic against the model.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3) == 0) begin
          set_req(i, AW'($urandom), BW'($urandom));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && ($urandom % 25) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = (($urandom % 4) != 0);
      rst = (($urandom % 400) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter that shares one external `adder` instance between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block registers the winning operands onto the adder inputs and waits one full clock for the adder to settle. It then captures the sum and returns it on a single response channel, tagged with the requester id.
- Sits between PE-level accumulate logic and the shared adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- A_WIDTH, 16, operand a width (signed).
- B_WIDTH, 16, operand b width (signed).
- OUT_WIDTH, max(A_WIDTH,B_WIDTH)+1, adder result width (signed).
- ID_WIDTH, $clog2(NUM_REQ), width of requester tag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  packed operands a; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed operands b, same packing.
- add_a  out  A_WIDTH  registered operand to adder a.
- add_b  out  B_WIDTH  registered operand to adder b.
- add_out  in  OUT_WIDTH  adder result.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer accept.
- rsp_id  out  ID_WIDTH  requester index of the result.
- rsp_data  out  OUT_WIDTH  captured sum.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all registers update on the rising edge of clk only.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - add_a=0, add_b=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - busy=0, req_ready=0.
- Reset mid-operation: an in-flight transaction is dropped silently; no response is ever issued for it.
- FSM states: IDLE, SETTLE, RESP.
- Arbitration (combinational, IDLE only):
  - Scan req_valid starting at index rr_ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins: grant index g.
  - req_ready[g]=1; all other req_ready bits are 0.
  - In SETTLE/RESP, req_ready=0.
  - No valid requests: req_ready=0 and state stays IDLE.
- Accept (IDLE, req_valid[g] & req_ready[g] at edge t):
  - add_a<=req_a[g], add_b<=req_b[g].
  - Store id g.
  - rr_ptr<=(g+1) mod NUM_REQ.
  - state<=SETTLE.
- SETTLE (cycle t+1):
  - add_a/add_b are stable for the full cycle so the adder's sub-cycle delay completes.
  - At edge t+1: rsp_data<=add_out, rsp_id<=stored id, rsp_valid<=1, state<=RESP.
  - add_out is never sampled in any other state.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid<=0, state<=IDLE.
  - With rsp_ready tied high: accept -> response visible 2 cycles later; throughput 1 op per 3 cycles.
- Operand hold: add_a/add_b keep their last value outside accept edges, so the adder does not toggle mid-cycle.
- Arithmetic: no width conversion inside this block; the adder owns sign extension and OUT_SCALE. rsp_data is add_out bit-for-bit.
- Requester rules:
  - A requester must hold req_valid, req_a and req_b stable until it sees req_ready.
  - Dropping req_valid before grant is legal; the request is then simply not served.
- Simultaneous events:
  - rsp handshake and new req_valid in the same cycle: the new request is not granted until the next cycle (IDLE).
  - Reset has priority over every other event.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- Assertions for the bench:
  - $onehot0(req_ready) at every cycle.
  - rsp_data/rsp_id stable while rsp_valid & !rsp_ready.

Test Plan:
- Single request: requester 2 sends a=100, b=-30 with rsp_ready=1 -> req_ready[2] at accept cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_data=70; busy high 2 cycles.
- Full contention: all 4 requesters valid, a=i, b=10*i, after reset -> responses in id order 0,1,2,3,0 with rsp_data 0,11,22,33; one accept every 3 cycles.
- Wrap-around: rr_ptr=3, requesters 1 and 3 valid -> 3 granted first, then 1; rr_ptr ends at 2.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with a=-32768, b=-1 -> rsp_data=-32769 held stable and no req_ready for all 5 cycles; IDLE one cycle after rsp_ready=1.
- Reset mid-op: rst asserted during SETTLE -> next cycle all outputs at reset values, no rsp_valid ever issued for the dropped op, rr_ptr=0.
- Idle stability: no req_valid for 20 cycles -> add_a/add_b unchanged, req_ready=0, busy=0.
